seq_serializer: RTL

Parallel-to-serial feeder directly upstream of the `1101` sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and buffers up to two words. It shifts them out one bit per clock on `dout`, which drives the detector's `din`. Consecutive words stream with no gap bits. When no word is pending, the line holds IDLE_BIT.

---
 rtl/seq_serializer.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: two-entry word FIFO feeding a gapless parallel-to-serial
// shifter that drives the 1101 detector input.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             push;
  logic             pop;
  logic             last;
  logic [WIDTH-1:0] head;

  assign in_ready = rst_n && (count < 2'd2);
  assign push     = in_valid && in_ready;
  assign last     = (state == SHIFT) && (bit_cnt == '0);
  assign pop      = (count != 2'd0) && ((state == IDLE) || last);
  assign head     = mem[rptr];
  assign busy     = (state == SHIFT) || (count != 2'd0);

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem[0]     <= '0;
      mem[1]     <= '0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      count      <= 2'd0;
      sreg       <= '0;
      bit_cnt    <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // a pop only happens from IDLE or on the last bit, so it
      // always means "start the next word now"
      if (pop) begin
        state      <= SHIFT;
        sreg       <= advance(head);
        dout       <= first_bit(head);
        dout_valid <= 1'b1;
        bit_cnt    <= CW'(WIDTH - 1);
        word_done  <= 1'b0;
      end else if (state == SHIFT && !last) begin
        sreg      <= advance(sreg);
        dout      <= first_bit(sreg);
        bit_cnt   <= bit_cnt - CW'(1);
        word_done <= (bit_cnt == CW'(1));
      end else if (state == SHIFT) begin
        state      <= IDLE;
        dout       <= IDLE_BIT;
        dout_valid <= 1'b0;
        word_done  <= 1'b0;
      end
    end
  end

endmodule
